// File: rtl/fmps_tx_link_arbiter_if.sv
// FMPS TX link arbiter stream bundle: NUM_SRC packet-source AXI-stream inputs
// and the single shared FMPS AXI-stream TX output toward Aurora.
// The slave modport is the arbiter's view; the master modport is the
// environment (sources plus Aurora TX sink).
interface fmps_tx_link_arbiter_if #(
    parameter int NUM_SRC    = 2,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_SRC*DATA_WIDTH-1:0] srcTdata;
    logic [NUM_SRC-1:0]            srcTvalid;
    logic [NUM_SRC-1:0]            srcTlast;
    logic [NUM_SRC-1:0]            srcTready;

    logic [DATA_WIDTH-1:0]         FMPS_AXI_STREAM_TX_tdata;
    logic                          FMPS_AXI_STREAM_TX_tvalid;
    logic                          FMPS_AXI_STREAM_TX_tlast;
    logic                          FMPS_AXI_STREAM_TX_tready;

    modport slave (
        input  srcTdata, srcTvalid, srcTlast,
        output srcTready,
        output FMPS_AXI_STREAM_TX_tdata, FMPS_AXI_STREAM_TX_tvalid, FMPS_AXI_STREAM_TX_tlast,
        input  FMPS_AXI_STREAM_TX_tready
    );

    modport master (
        output srcTdata, srcTvalid, srcTlast,
        input  srcTready,
        input  FMPS_AXI_STREAM_TX_tdata, FMPS_AXI_STREAM_TX_tvalid, FMPS_AXI_STREAM_TX_tlast,
        output FMPS_AXI_STREAM_TX_tready
    );
endinterface

// File: rtl/fmps_tx_link_arbiter.sv
// fmps_tx_link_arbiter: packet-level round-robin arbiter sharing one FMPS
// AXI-stream TX link (Aurora user clock domain) between NUM_SRC sources.
// Grant is held from header to tlast so frames never interleave; the
// round-robin pointer restarts at each FA session strobe.
// Optional build macro FMPS_ARB_TIMEOUT_EN adds a source-stall watchdog that
// aborts a stalled packet with a 0xDEAD marker beat and drains the rest.
module fmps_tx_link_arbiter #(
    parameter int NUM_SRC        = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 auroraUserClk,
    input  logic                 auroraUserRst_n,
    input  logic                 auroraFAstrobe,
    input  logic                 auroraChannelUp,
    fmps_tx_link_arbiter_if.slave linkIf,
    output logic [2:0]           grantIndex,
    output logic                 busy,
    output logic [15:0]          sessionPktCount,
    output logic [7:0]           timeoutCount
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PASS  = 2'd1;
`ifdef FMPS_ARB_TIMEOUT_EN
    localparam logic [1:0] ABORT = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;
`endif

    logic [1:0]            stateReg;
    logic [2:0]            rrPtr;
    logic                  pendingStrobe;
    logic [NUM_SRC-1:0]    grantOh;
    logic [DATA_WIDTH-1:0] selData;
    logic                  selValid;
    logic                  selLast;
    logic [NUM_SRC-1:0]    reqRot;
    logic [2:0]            reqOffset;
    logic [3:0]            reqSum;
    logic [2:0]            nextGrant;
    logic [2:0]            grantPlus1;
    logic [2:0]            rrAtEnd;
    logic                  beatAccept;
    logic                  pktDone;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : gGrantOh
            assign grantOh[gi] = (grantIndex == 3'(gi));
        end
    endgenerate

    // Mux the granted source's stream signals onto the shared path
    always_comb begin
        selData  = '0;
        selValid = 1'b0;
        selLast  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grantOh[i]) begin
                selData  = linkIf.srcTdata[i*DATA_WIDTH +: DATA_WIDTH];
                selValid = linkIf.srcTvalid[i];
                selLast  = linkIf.srcTlast[i];
            end
        end
    end

    // Rotate requests so bit 0 is rrPtr; lowest set bit is the next winner
    assign reqRot = NUM_SRC'({linkIf.srcTvalid, linkIf.srcTvalid} >> rrPtr);

    // Priority-encode the rotated request vector
    always_comb begin
        reqOffset = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (reqRot[i]) reqOffset = 3'(i);
        end
    end

    assign reqSum     = {1'b0, rrPtr} + {1'b0, reqOffset};
    assign nextGrant  = (reqSum >= 4'(NUM_SRC)) ? 3'(reqSum - 4'(NUM_SRC)) : reqSum[2:0];
    assign grantPlus1 = (grantIndex == 3'(NUM_SRC - 1)) ? 3'd0 : grantIndex + 3'd1;
    // A session strobe seen during or at the end of a packet restarts priority at 0
    assign rrAtEnd    = (pendingStrobe || auroraFAstrobe) ? 3'd0 : grantPlus1;
    assign beatAccept = selValid && linkIf.FMPS_AXI_STREAM_TX_tready;
    assign pktDone    = (stateReg == PASS) && beatAccept && selLast;
    assign busy       = (stateReg != IDLE);

    // Drive TX and per-source ready from the current state
    always_comb begin
        linkIf.FMPS_AXI_STREAM_TX_tdata  = '0;
        linkIf.FMPS_AXI_STREAM_TX_tvalid = 1'b0;
        linkIf.FMPS_AXI_STREAM_TX_tlast  = 1'b0;
        linkIf.srcTready                 = '0;
        case (stateReg)
            PASS: begin
                linkIf.FMPS_AXI_STREAM_TX_tdata  = selData;
                linkIf.FMPS_AXI_STREAM_TX_tvalid = selValid;
                linkIf.FMPS_AXI_STREAM_TX_tlast  = selLast;
                linkIf.srcTready = grantOh & {NUM_SRC{linkIf.FMPS_AXI_STREAM_TX_tready}};
            end
`ifdef FMPS_ARB_TIMEOUT_EN
            ABORT: begin
                linkIf.FMPS_AXI_STREAM_TX_tdata  = DATA_WIDTH'({16'hDEAD, 13'b0, grantIndex});
                linkIf.FMPS_AXI_STREAM_TX_tvalid = 1'b1;
                linkIf.FMPS_AXI_STREAM_TX_tlast  = 1'b1;
            end
            DRAIN: begin
                linkIf.srcTready = grantOh;
            end
`endif
            default: ;
        endcase
    end

`ifdef FMPS_ARB_TIMEOUT_EN
    logic [15:0] stallCnt;
`else
    assign timeoutCount = 8'd0;
`endif

    // Arbiter FSM, round-robin pointer, session and timeout counters
    always_ff @(posedge auroraUserClk or negedge auroraUserRst_n) begin
        if (!auroraUserRst_n) begin
            stateReg        <= IDLE;
            grantIndex      <= 3'd0;
            rrPtr           <= 3'd0;
            pendingStrobe   <= 1'b0;
            sessionPktCount <= 16'd0;
`ifdef FMPS_ARB_TIMEOUT_EN
            stallCnt        <= 16'd0;
            timeoutCount    <= 8'd0;
`endif
        end else begin
            // The strobe wins over a packet ending the same cycle (old session)
            if (auroraFAstrobe) sessionPktCount <= 16'd0;
            else if (pktDone)   sessionPktCount <= sessionPktCount + 16'd1;

            if (auroraFAstrobe && stateReg != IDLE) pendingStrobe <= 1'b1;

            case (stateReg)
                IDLE: begin
                    if (auroraFAstrobe) rrPtr <= 3'd0;
                    if (auroraChannelUp && (|linkIf.srcTvalid)) begin
                        grantIndex <= nextGrant;
                        stateReg   <= PASS;
`ifdef FMPS_ARB_TIMEOUT_EN
                        stallCnt   <= 16'd0;
`endif
                    end
                end
                PASS: begin
                    if (beatAccept) begin
`ifdef FMPS_ARB_TIMEOUT_EN
                        stallCnt <= 16'd0;
`endif
                        if (selLast) begin
                            stateReg      <= IDLE;
                            rrPtr         <= rrAtEnd;
                            pendingStrobe <= 1'b0;
                        end
                    end
`ifdef FMPS_ARB_TIMEOUT_EN
                    else if (stallCnt == 16'(TIMEOUT_CYCLES)) begin
                        stateReg <= ABORT;
                    end else if (!selValid) begin
                        stallCnt <= stallCnt + 16'd1;
                    end
`endif
                end
`ifdef FMPS_ARB_TIMEOUT_EN
                ABORT: begin
                    if (linkIf.FMPS_AXI_STREAM_TX_tready) begin
                        stateReg <= DRAIN;
                        if (timeoutCount != 8'hFF) timeoutCount <= timeoutCount + 8'd1;
                    end
                end
                DRAIN: begin
                    if (selValid && selLast) begin
                        stateReg      <= IDLE;
                        rrPtr         <= rrAtEnd;
                        pendingStrobe <= 1'b0;
                    end
                end
`endif
                default: stateReg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fmps_tx_link_arbiter.sv
// Directed testbench for fmps_tx_link_arbiter (NUM_SRC=2, DATA_WIDTH=32).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_fmps_tx_link_arbiter;
    localparam int NS = 2;
    localparam int DW = 32;
`ifdef FMPS_ARB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        faStrobe;
    logic        chanUp;
    logic [2:0]  grantIndex;
    logic        busy;
    logic [15:0] sessionPktCount;
    logic [7:0]  timeoutCount;
    int          checks = 0;
    int          errors = 0;

    fmps_tx_link_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) linkIf ();

    fmps_tx_link_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .auroraUserClk   (clk),
        .auroraUserRst_n (rst_n),
        .auroraFAstrobe  (faStrobe),
        .auroraChannelUp (chanUp),
        .linkIf          (linkIf),
        .grantIndex      (grantIndex),
        .busy            (busy),
        .sessionPktCount (sessionPktCount),
        .timeoutCount    (timeoutCount)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic l, input logic [31:0] d);
        linkIf.srcTvalid[i] = v;
        linkIf.srcTlast[i]  = l;
        linkIf.srcTdata[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step(); settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0h want=0", busy); end
        checks++; if (linkIf.FMPS_AXI_STREAM_TX_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got=%0h want=0", linkIf.FMPS_AXI_STREAM_TX_tvalid); end
        checks++; if (grantIndex !== 3'd0) begin errors++; $display("FAIL rst_grant got=%0h want=0", grantIndex); end
        rst_n = 1'b1;
        // single-beat packet from src0
        drive(0, 1'b1, 1'b1, 32'h1111_0001);
        step(); settle();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sb_busy got=%0h want=1", busy); end
        checks++; if (linkIf.FMPS_AXI_STREAM_TX_tdata !== 32'h1111_0001) begin errors++; $display("FAIL sb_tdata got=%0h want=11110001", linkIf.FMPS_AXI_STREAM_TX_tdata); end
        checks++; if (linkIf.FMPS_AXI_STREAM_TX_tlast !== 1'b1) begin errors++; $display("FAIL sb_tlast got=%0h want=1", linkIf.FMPS_AXI_STREAM_TX_tlast); end
        checks++; if (linkIf.srcTready !== 2'b01) begin errors++; $display("FAIL sb_ready got=%0h want=1", linkIf.srcTready); end
        step(); drive(0, 1'b0, 1'b0, 32'h0); settle();
        checks++; if (sessionPktCount !== 16'd1) begin errors++; $display("FAIL sb_count got=%0d want=1", sessionPktCount); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sb_idle got=%0h want=0", busy); end
        // 4-beat src0 packet, reset after two beats
        drive(0, 1'b1, 1'b0, 32'h2222_0000);
        step(); settle();
        checks++; if (grantIndex !== 3'd0 || busy !== 1'b1) begin errors++; $display("FAIL mp_grant got=%0h/%0h want=0/1", grantIndex, busy); end
        step(); drive(0, 1'b1, 1'b0, 32'h2222_0001);
        step(); drive(0, 1'b1, 1'b0, 32'h2222_0002); settle();
        checks++; if (linkIf.FMPS_AXI_STREAM_TX_tdata !== 32'h2222_0002) begin errors++; $display("FAIL mp_beat2 got=%0h want=22220002", linkIf.FMPS_AXI_STREAM_TX_tdata); end
        rst_n = 1'b0;
        step(); settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy got=%0h want=0", busy); end
        checks++; if (linkIf.FMPS_AXI_STREAM_TX_tvalid !== 1'b0 || linkIf.FMPS_AXI_STREAM_TX_tlast !== 1'b0) begin errors++; $display("FAIL mr_tx got=%0h/%0h want=0/0", linkIf.FMPS_AXI_STREAM_TX_tvalid, linkIf.FMPS_AXI_STREAM_TX_tlast); end
        checks++; if (linkIf.FMPS_AXI_STREAM_TX_tdata !== 32'h0) begin errors++; $display("FAIL mr_tdata got=%0h want=0", linkIf.FMPS_AXI_STREAM_TX_tdata); end
        checks++; if (linkIf.srcTready !== 2'b00) begin errors++; $display("FAIL mr_ready got=%0h want=0", linkIf.srcTready); end
        checks++; if (sessionPktCount !== 16'd0) begin errors++; $display("FAIL mr_count got=%0d want=0", sessionPktCount); end
        // after release only src1 requests
        drive(0, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b1, 1'b1, 32'h3333_0001);
        rst_n = 1'b1;
        step(); settle();
        checks++; if (grantIndex !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL ar_grant got=%0h/%0h want=1/1", grantIndex, busy); end
        step(); drive(1, 1'b0, 1'b0, 32'h0); settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_done got=%0h want=0", busy); end
    endtask

    task automatic test_round_robin();
        int beat[2];
        int pkt[2];
        int k = 0;
        int age = 99;
        int cyc = 0;
        logic [1:0]  rdy;
        logic [31:0] expd;
        faStrobe = 1'b1; step(); faStrobe = 1'b0; settle();
        checks++; if (sessionPktCount !== 16'd0) begin errors++; $display("FAIL rr_strobe_count got=%0d want=0", sessionPktCount); end
        for (int i = 0; i < 2; i++) begin beat[i] = 0; pkt[i] = 0; end
        while (k < 12 && cyc < 80) begin
            for (int i = 0; i < 2; i++) begin
                if (pkt[i] < 2) drive(i, 1'b1, beat[i] == 2, 32'hA000_0000 | (i << 16) | (pkt[i] << 8) | beat[i]);
                else            drive(i, 1'b0, 1'b0, 32'h0);
            end
            settle();
            if (age == 1) begin
                checks++; if (linkIf.FMPS_AXI_STREAM_TX_tvalid !== 1'b0) begin errors++; $display("FAIL rr_bubble word=%0d got=%0h want=0", k, linkIf.FMPS_AXI_STREAM_TX_tvalid); end
            end else if (age == 2) begin
                checks++; if (linkIf.FMPS_AXI_STREAM_TX_tvalid !== 1'b1) begin errors++; $display("FAIL rr_regrant word=%0d got=%0h want=1", k, linkIf.FMPS_AXI_STREAM_TX_tvalid); end
            end
            if (age < 99) age++;
            if (linkIf.FMPS_AXI_STREAM_TX_tvalid === 1'b1) begin
                expd = 32'hA000_0000 | (((k / 3) % 2) << 16) | ((k / 6) << 8) | (k % 3);
                checks++; if (linkIf.FMPS_AXI_STREAM_TX_tdata !== expd) begin errors++; $display("FAIL rr_data word=%0d got=%0h want=%0h", k, linkIf.FMPS_AXI_STREAM_TX_tdata, expd); end
                checks++; if (linkIf.FMPS_AXI_STREAM_TX_tlast !== ((k % 3) == 2)) begin errors++; $display("FAIL rr_last word=%0d got=%0h want=%0h", k, linkIf.FMPS_AXI_STREAM_TX_tlast, (k % 3) == 2); end
                if (linkIf.FMPS_AXI_STREAM_TX_tlast === 1'b1) age = 1;
                k++;
            end
            rdy = linkIf.srcTready;
            for (int i = 0; i < 2; i++) begin
                if (rdy[i] && pkt[i] < 2) begin
                    beat[i]++;
                    if (beat[i] == 3) begin beat[i] = 0; pkt[i]++; end
                end
            end
            step();
            cyc++;
        end
        checks++; if (k != 12) begin errors++; $display("FAIL rr_timeout got=%0d want=12 words", k); end
        drive(0, 1'b0, 1'b0, 32'h0); drive(1, 1'b0, 1'b0, 32'h0); settle();
        checks++; if (sessionPktCount !== 16'd4) begin errors++; $display("FAIL rr_count got=%0d want=4", sessionPktCount); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle got=%0h want=0", busy); end
    endtask

    task automatic test_tready_toggle();
        int beat = 0;
        int cyc = 0;
        logic rdyNow;
        drive(1, 1'b1, 1'b0, 32'h5000_0000);
        step();
        while (beat < 5 && cyc < 40) begin
            rdyNow = (cyc % 2) == 1;
            linkIf.FMPS_AXI_STREAM_TX_tready = rdyNow;
            drive(1, 1'b1, beat == 4, 32'h5000_0000 + beat);
            settle();
            checks++; if (linkIf.srcTready !== {rdyNow, 1'b0}) begin errors++; $display("FAIL tg_ready cyc=%0d got=%0h want=%0h", cyc, linkIf.srcTready, {rdyNow, 1'b0}); end
            checks++; if (linkIf.FMPS_AXI_STREAM_TX_tdata !== 32'h5000_0000 + beat) begin errors++; $display("FAIL tg_data cyc=%0d got=%0h want=%0h", cyc, linkIf.FMPS_AXI_STREAM_TX_tdata, 32'h5000_0000 + beat); end
            checks++; if (linkIf.FMPS_AXI_STREAM_TX_tlast !== (beat == 4)) begin errors++; $display("FAIL tg_last cyc=%0d got=%0h want=%0h", cyc, linkIf.FMPS_AXI_STREAM_TX_tlast, beat == 4); end
            if (rdyNow) beat++;
            step();
            cyc++;
        end
        checks++; if (beat != 5) begin errors++; $display("FAIL tg_timeout got=%0d want=5 beats", beat); end
        drive(1, 1'b0, 1'b0, 32'h0);
        linkIf.FMPS_AXI_STREAM_TX_tready = 1'b1;
        settle();
        checks++; if (busy !== 1'b0 || sessionPktCount !== 16'd5) begin errors++; $display("FAIL tg_end got=%0h/%0d want=0/5", busy, sessionPktCount); end
    endtask

    task automatic test_channel_strobe();
        chanUp = 1'b0;
        drive(0, 1'b1, 1'b1, 32'h6000_0000);
        for (int c = 0; c < 10; c++) begin
            step(); settle();
            checks++; if (busy !== 1'b0 || linkIf.FMPS_AXI_STREAM_TX_tvalid !== 1'b0) begin errors++; $display("FAIL ch_nogrant cyc=%0d got=%0h/%0h want=0/0", c, busy, linkIf.FMPS_AXI_STREAM_TX_tvalid); end
        end
        chanUp = 1'b1;
        step(); settle();
        checks++; if (busy !== 1'b1 || grantIndex !== 3'd0) begin errors++; $display("FAIL ch_grant got=%0h/%0h want=1/0", busy, grantIndex); end
        step(); drive(0, 1'b0, 1'b0, 32'h0); settle();
        checks++; if (sessionPktCount !== 16'd6) begin errors++; $display("FAIL ch_count got=%0d want=6", sessionPktCount); end
        // src1 3-beat packet with a strobe on its middle beat
        drive(1, 1'b1, 1'b0, 32'h7000_0000);
        step(); drive(0, 1'b1, 1'b1, 32'h6000_0001); settle();
        checks++; if (grantIndex !== 3'd1) begin errors++; $display("FAIL fa_grant1 got=%0h want=1", grantIndex); end
        step(); drive(1, 1'b1, 1'b0, 32'h7000_0001); faStrobe = 1'b1;
        step(); faStrobe = 1'b0; drive(1, 1'b1, 1'b1, 32'h7000_0002); settle();
        checks++; if (sessionPktCount !== 16'd0) begin errors++; $display("FAIL fa_count0 got=%0d want=0", sessionPktCount); end
        checks++; if (busy !== 1'b1 || linkIf.srcTready !== 2'b10) begin errors++; $display("FAIL fa_held got=%0h/%0h want=1/2", busy, linkIf.srcTready); end
        step(); drive(1, 1'b0, 1'b0, 32'h0); settle();
        checks++; if (busy !== 1'b0 || sessionPktCount !== 16'd1) begin errors++; $display("FAIL fa_end got=%0h/%0d want=0/1", busy, sessionPktCount); end
        step(); settle();
        checks++; if (grantIndex !== 3'd0 || linkIf.FMPS_AXI_STREAM_TX_tdata !== 32'h6000_0001) begin errors++; $display("FAIL fa_next got=%0h/%0h want=0/60000001", grantIndex, linkIf.FMPS_AXI_STREAM_TX_tdata); end
        // strobe on the very cycle the packet ends: counted in the old session
        faStrobe = 1'b1;
        step(); faStrobe = 1'b0; drive(0, 1'b0, 1'b0, 32'h0); settle();
        checks++; if (sessionPktCount !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL fa_same_cycle got=%0d/%0h want=0/0", sessionPktCount, busy); end
    endtask

    task automatic test_stall();
        drive(1, 1'b1, 1'b0, 32'h8000_00AA);
        step(); settle();
        checks++; if (grantIndex !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL st_grant got=%0h/%0h want=1/1", grantIndex, busy); end
        step(); drive(1, 1'b0, 1'b0, 32'h0);
`ifdef FMPS_ARB_TIMEOUT_EN
        begin
            int waited = 0;
            settle();
            while (waited < 20) begin
                if (linkIf.FMPS_AXI_STREAM_TX_tvalid === 1'b1) break;
                step(); settle();
                waited++;
            end
            checks++; if (waited != 5) begin errors++; $display("FAIL to_delay got=%0d want=5", waited); end
            checks++; if (linkIf.FMPS_AXI_STREAM_TX_tdata !== 32'hDEAD0001 || linkIf.FMPS_AXI_STREAM_TX_tlast !== 1'b1) begin errors++; $display("FAIL to_marker got=%0h/%0h want=dead0001/1", linkIf.FMPS_AXI_STREAM_TX_tdata, linkIf.FMPS_AXI_STREAM_TX_tlast); end
            checks++; if (linkIf.srcTready !== 2'b00) begin errors++; $display("FAIL to_abort_ready got=%0h want=0", linkIf.srcTready); end
            step(); drive(1, 1'b1, 1'b0, 32'h8000_00BB); settle();
            checks++; if (linkIf.FMPS_AXI_STREAM_TX_tvalid !== 1'b0 || linkIf.srcTready !== 2'b10) begin errors++; $display("FAIL to_drain got=%0h/%0h want=0/2", linkIf.FMPS_AXI_STREAM_TX_tvalid, linkIf.srcTready); end
            checks++; if (timeoutCount !== 8'd1) begin errors++; $display("FAIL to_count got=%0d want=1", timeoutCount); end
            step(); drive(1, 1'b1, 1'b1, 32'h8000_00CC); settle();
            checks++; if (linkIf.FMPS_AXI_STREAM_TX_tvalid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_drain_last got=%0h/%0h want=0/1", linkIf.FMPS_AXI_STREAM_TX_tvalid, busy); end
            step(); drive(1, 1'b0, 1'b0, 32'h0); settle();
            checks++; if (busy !== 1'b0 || timeoutCount !== 8'd1 || sessionPktCount !== 16'd0) begin errors++; $display("FAIL to_end got=%0h/%0d/%0d want=0/1/0", busy, timeoutCount, sessionPktCount); end
        end
`else
        repeat (20) step();
        settle();
        checks++; if (busy !== 1'b1 || grantIndex !== 3'd1) begin errors++; $display("FAIL st_wait got=%0h/%0h want=1/1", busy, grantIndex); end
        checks++; if (linkIf.FMPS_AXI_STREAM_TX_tvalid !== 1'b0 || timeoutCount !== 8'd0) begin errors++; $display("FAIL st_idle_tx got=%0h/%0d want=0/0", linkIf.FMPS_AXI_STREAM_TX_tvalid, timeoutCount); end
        drive(1, 1'b1, 1'b1, 32'h8000_00DD); settle();
        checks++; if (linkIf.FMPS_AXI_STREAM_TX_tdata !== 32'h8000_00DD || linkIf.FMPS_AXI_STREAM_TX_tlast !== 1'b1) begin errors++; $display("FAIL st_resume got=%0h/%0h want=800000dd/1", linkIf.FMPS_AXI_STREAM_TX_tdata, linkIf.FMPS_AXI_STREAM_TX_tlast); end
        step(); drive(1, 1'b0, 1'b0, 32'h0); settle();
        checks++; if (busy !== 1'b0 || sessionPktCount !== 16'd1 || timeoutCount !== 8'd0) begin errors++; $display("FAIL st_end got=%0h/%0d/%0d want=0/1/0", busy, sessionPktCount, timeoutCount); end
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        faStrobe = 1'b0;
        chanUp   = 1'b1;
        linkIf.srcTdata  = '0;
        linkIf.srcTvalid = '0;
        linkIf.srcTlast  = '0;
        linkIf.FMPS_AXI_STREAM_TX_tready = 1'b1;
        test_reset();
        test_round_robin();
        test_tready_toggle();
        test_channel_strobe();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
